// File: rtl/load_merge_unit.sv
// Load-completion stage: in-order queue of outstanding loads, store-forward byte merge,
// align/extend, registered PRF writeback and a one-cycle-later ROB commit.
module load_merge_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PRF_W = 6,
    parameter int ROB_W = 6,
    localparam int NB    = XLEN / 8,
    localparam int OFS_W = $clog2(NB),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ROB_W-1:0] req_rob_tag,
    input  logic [PRF_W-1:0] req_rd,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [OFS_W-1:0] req_offset,
    input  logic [NB-1:0]    req_fwd_mask,
    input  logic [XLEN-1:0]  req_fwd_data,
    input  logic             resp_valid,
    input  logic [XLEN-1:0]  resp_data,
    output logic             wb_valid,
    output logic [PRF_W-1:0] wb_addr,
    output logic [XLEN-1:0]  wb_data,
    output logic             commit_valid,
    output logic [ROB_W-1:0] commit_tag,
    output logic [CNT_W-1:0] pending_count,
    output logic             resp_orphan
);
    localparam int PTR_W  = $clog2(DEPTH);
    // Dropped responses can outlive several flushes, so this counter is wider than the queue count.
    localparam int DROP_W = CNT_W + 4;

    logic [ROB_W-1:0] tag_r  [DEPTH];
    logic [PRF_W-1:0] rd_r   [DEPTH];
    logic [1:0]       size_r [DEPTH];
    logic             uns_r  [DEPTH];
    logic [OFS_W-1:0] ofs_r  [DEPTH];
    logic [NB-1:0]    mask_r [DEPTH];
    logic [XLEN-1:0]  fwd_r  [DEPTH];
    logic [XLEN-1:0]  data_r [DEPTH];
    logic             has_r  [DEPTH];

    logic [PTR_W-1:0]  head_r, tail_r, rptr_r;
    logic [CNT_W-1:0]  count_r, wait_r;
    logic [DROP_W-1:0] drop_r;
    logic [ROB_W-1:0]  wb_tag_r;
    logic              fresh_r;

    logic              full_s, enq_s, drop_hit_s, cap_s, orphan_s, bypass_s, pop_s;
    logic [XLEN-1:0]   head_mem_s, head_res_s;

    // Merge forwarded bytes over memory bytes, shift down to the access, then extend.
    function automatic logic [XLEN-1:0] load_result(
        input logic [NB-1:0]    mask,
        input logic [XLEN-1:0]  fwd,
        input logic [XLEN-1:0]  mem,
        input logic [OFS_W-1:0] ofs,
        input logic [1:0]       size,
        input logic             uns
    );
        logic [XLEN-1:0] merged;
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] low_mask;
        logic            sbit;
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = mask[i] ? fwd[8*i +: 8] : mem[8*i +: 8];
        end
        shifted = merged >> {ofs, 3'b000};
        case (size)
            2'b00:   begin low_mask = XLEN'(8'hFF);         sbit = shifted[7];      end
            2'b01:   begin low_mask = XLEN'(16'hFFFF);      sbit = shifted[15];     end
            2'b10:   begin low_mask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31];     end
            default: begin low_mask = {XLEN{1'b1}};         sbit = shifted[XLEN-1]; end
        endcase
        if (uns || !sbit) begin
            load_result = shifted & low_mask;
        end else begin
            load_result = shifted | ~low_mask;
        end
    endfunction

    // Handshake, response routing and head-completion decode.
    always_comb begin
        full_s     = (count_r == CNT_W'(DEPTH));
        req_ready  = !full_s && !stall && !flush;
        enq_s      = req_valid && req_ready;
        drop_hit_s = resp_valid && (drop_r != '0);
        cap_s      = resp_valid && (drop_r == '0) && (wait_r != '0);
        orphan_s   = resp_valid && (drop_r == '0) && (wait_r == '0);
        bypass_s   = cap_s && (rptr_r == head_r);
        pop_s      = !stall && !flush && (count_r != '0) && (has_r[head_r] || bypass_s);
        if (bypass_s) begin
            head_mem_s = resp_data;
        end else begin
            head_mem_s = data_r[head_r];
        end
        head_res_s = load_result(mask_r[head_r], fwd_r[head_r], head_mem_s,
                                 ofs_r[head_r], size_r[head_r], uns_r[head_r]);
    end

    assign pending_count = count_r;

    // Pointers, occupancy, waiting-for-data count and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            wait_r  <= '0;
            drop_r  <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            wait_r  <= '0;
            drop_r  <= drop_r + DROP_W'(wait_r) - DROP_W'(drop_hit_s || cap_s);
        end else begin
            if (enq_s) tail_r <= tail_r + PTR_W'(1);
            if (cap_s) rptr_r <= rptr_r + PTR_W'(1);
            if (pop_s) head_r <= head_r + PTR_W'(1);
            count_r <= count_r + CNT_W'(enq_s) - CNT_W'(pop_s);
            wait_r  <= wait_r + CNT_W'(enq_s) - CNT_W'(cap_s);
            drop_r  <= drop_r - DROP_W'(drop_hit_s);
        end
    end

    // Entry payload: request fields at tail, memory data at rptr.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            tag_r[tail_r]  <= req_rob_tag;
            rd_r[tail_r]   <= req_rd;
            size_r[tail_r] <= req_size;
            uns_r[tail_r]  <= req_unsigned;
            ofs_r[tail_r]  <= req_offset;
            mask_r[tail_r] <= req_fwd_mask;
            fwd_r[tail_r]  <= req_fwd_data;
        end
        if (cap_s) begin
            data_r[rptr_r] <= resp_data;
        end
    end

    // Per-entry data-present flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) has_r[i] <= 1'b0;
        end else begin
            if (enq_s) has_r[tail_r] <= 1'b0;
            if (cap_s) has_r[rptr_r] <= 1'b1;
        end
    end

    // Writeback register; fresh_r marks the first cycle of each writeback so commit fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_tag_r <= '0;
            fresh_r  <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            fresh_r  <= 1'b0;
        end else if (stall) begin
            fresh_r  <= 1'b0;
        end else begin
            wb_valid <= pop_s;
            fresh_r  <= pop_s;
            if (pop_s) begin
                wb_addr  <= rd_r[head_r];
                wb_data  <= head_res_s;
                wb_tag_r <= tag_r[head_r];
            end
        end
    end

    // Commit and orphan pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            resp_orphan  <= 1'b0;
        end else begin
            commit_valid <= wb_valid && fresh_r;
            commit_tag   <= wb_tag_r;
            resp_orphan  <= orphan_s;
        end
    end
endmodule
